memory_arbiter: RTL and testbench
=================================

MEMORY_ARBITER -- requirements
Module: memory_arbiter

Interface
REQ-001 Parameter ADDR_W, default 7, SHALL set the RAM address width (128 locations).
REQ-002 Parameter DATA_W, default 8, SHALL set the RAM data width.
REQ-003 clk  input  1  SHALL be the single clock; all state updates on its rising edge.
REQ-004 reset  input  1  SHALL be the reset, asynchronous and active-high.
REQ-005 req0/req1  input  1 each  SHALL be requester 0/1 access request, level, held until ack.
REQ-006 we0/we1  input  1 each  SHALL select write (1) or read (0) for the matching requester.
REQ-007 addr0/addr1  input  ADDR_W each  SHALL be the requester target address.
REQ-008 wdata0/wdata1  input  DATA_W each  SHALL be the requester write data.
REQ-009 ack0/ack1  output  1 each  SHALL pulse high one cycle on transaction completion.
REQ-010 rdata  output  DATA_W  SHALL be the shared read-data return, valid while ack0 or ack1 is high on a read.
REQ-011 busy  output  1  SHALL be high whenever the FSM is not in IDLE.
REQ-012 mem_en, mem_read, mem_write  output  1 each  SHALL drive the RAM enable and read/write strobes.
REQ-013 mem_addr  output  ADDR_W; mem_wdata  output  DATA_W; SHALL drive the RAM address and input data.
REQ-014 mem_rdata  input  DATA_W  SHALL be the RAM read data.

Function
REQ-015 FSM states SHALL be IDLE, ACCESS, RESP; transitions IDLE->ACCESS on any req, ACCESS->RESP unconditionally, RESP->IDLE unconditionally.
REQ-016 In IDLE with a request sampled at edge N, the FSM SHALL latch the grant, we, addr and wdata of the winner at edge N.
REQ-017 During ACCESS (cycle N+1), mem_en SHALL be 1, mem_read SHALL equal ~we, mem_write SHALL equal we, and mem_addr/mem_wdata SHALL hold the latched values.
REQ-018 mem_read and mem_write SHALL never both be 1; in IDLE and RESP, mem_en, mem_read and mem_write SHALL be 0.
REQ-019 On a read, rdata SHALL capture mem_rdata at the ACCESS->RESP edge; on a write, rdata SHALL hold its previous value.
REQ-020 In RESP (cycle N+2), exactly the granted ack SHALL be 1; fixed latency request-sample to ack is 2 cycles.
REQ-021 With both requests high in IDLE, grant SHALL go to the requester not granted last (round-robin via a 1-bit last_grant register).
REQ-022 last_grant SHALL update only when a grant is latched; with a single request, that requester SHALL be granted regardless of last_grant.
REQ-023 Request changes during ACCESS/RESP SHALL be ignored; requests are sampled only in IDLE.
REQ-024 A requester still asserting req in the cycle after its ack SHALL be treated as a new transaction.
REQ-025 Back-to-back transactions SHALL be accepted every 3 cycles; under continuous dual requests grants SHALL alternate 0,1,0,1...
REQ-026 All outputs SHALL be registered; no combinational path from req*/addr* to mem_*.

Reset
REQ-027 On reset, the FSM SHALL enter IDLE immediately, with ack0=ack1=0, busy=0, mem_en=mem_read=mem_write=0, mem_addr=0, mem_wdata=0, rdata=0, last_grant=1 (requester 0 wins first tie).
REQ-028 Reset asserted mid-transaction SHALL abort it without ack or retry; a write aborted during ACCESS has an undefined effect on the RAM location.

Structure
REQ-029 FSM state encoding and ADDR_W/DATA_W defaults SHALL live in a shared package used with the memory block.
REQ-030 The arbiter SHALL be a single module with no sub-modules; the RAM instance SHALL stay outside it.

Verification
REQ-031 Write: req0=1, we0=1, addr0=5, wdata0=8'd42 -> mem_write=1 at cycle+1, ack0 at cycle+2; a subsequent read of addr 5 returns rdata=42.
REQ-032 Tie: req0=req1=1 after reset -> ack0 first, then ack1 three cycles later; sustained ties alternate grants.
REQ-033 Single request: req1 alone, twice in a row -> requester 1 granted both times.
REQ-034 Reset asserted in ACCESS -> all outputs reach reset values asynchronously, no ack.
REQ-035 Every cycle: assert !(mem_read && mem_write), at most one ack high, mem_en=0 outside ACCESS.

Source files
------------

// File: rtl/memory_arbiter_pkg.sv
// Shared definitions for the two-port memory arbiter and the RAM it fronts:
// FSM encoding, default geometry and the round-robin grant decision.
package memory_arbiter_pkg;

    localparam int ADDR_W_DEF = 7;
    localparam int DATA_W_DEF = 8;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_RESP   = 2'd2
    } arb_state_t;

    // Returns the winning requester index (0 or 1); a tie goes to whoever did not win last.
    function automatic logic pick_grant(input logic req0, input logic req1, input logic last_grant);
        if (req0 && req1) begin
            return ~last_grant;
        end
        return req1;
    endfunction

endpackage

// File: rtl/memory_arbiter.sv
// Round-robin arbiter giving two requesters fixed-latency access to a single-port RAM.
// Every output is a register; requests are sampled only while idle.
module memory_arbiter
    import memory_arbiter_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DATA_W = DATA_W_DEF
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req0,
    input  logic              req1,
    input  logic              we0,
    input  logic              we1,
    input  logic [ADDR_W-1:0] addr0,
    input  logic [ADDR_W-1:0] addr1,
    input  logic [DATA_W-1:0] wdata0,
    input  logic [DATA_W-1:0] wdata1,
    output logic              ack0,
    output logic              ack1,
    output logic [DATA_W-1:0] rdata,
    output logic              busy,
    output logic              mem_en,
    output logic              mem_read,
    output logic              mem_write,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
);

    arb_state_t        state_q, state_d;
    logic              grant_q, grant_d;
    logic              last_grant_q, last_grant_d;
    logic              ack0_q, ack0_d;
    logic              ack1_q, ack1_d;
    logic              busy_q, busy_d;
    logic              mem_en_q, mem_en_d;
    logic              mem_read_q, mem_read_d;
    logic              mem_write_q, mem_write_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;
    logic              gnt_sel;
    logic              we_sel;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            grant_q      <= 1'b0;
            last_grant_q <= 1'b1;
            ack0_q       <= 1'b0;
            ack1_q       <= 1'b0;
            busy_q       <= 1'b0;
            mem_en_q     <= 1'b0;
            mem_read_q   <= 1'b0;
            mem_write_q  <= 1'b0;
            mem_addr_q   <= '0;
            mem_wdata_q  <= '0;
            rdata_q      <= '0;
        end else begin
            state_q      <= state_d;
            grant_q      <= grant_d;
            last_grant_q <= last_grant_d;
            ack0_q       <= ack0_d;
            ack1_q       <= ack1_d;
            busy_q       <= busy_d;
            mem_en_q     <= mem_en_d;
            mem_read_q   <= mem_read_d;
            mem_write_q  <= mem_write_d;
            mem_addr_q   <= mem_addr_d;
            mem_wdata_q  <= mem_wdata_d;
            rdata_q      <= rdata_d;
        end
    end

    // Strobes and acks default low so each is a single-cycle pulse in its own state.
    always_comb begin
        state_d      = state_q;
        grant_d      = grant_q;
        last_grant_d = last_grant_q;
        ack0_d       = 1'b0;
        ack1_d       = 1'b0;
        mem_en_d     = 1'b0;
        mem_read_d   = 1'b0;
        mem_write_d  = 1'b0;
        mem_addr_d   = mem_addr_q;
        mem_wdata_d  = mem_wdata_q;
        rdata_d      = rdata_q;
        gnt_sel      = pick_grant(req0, req1, last_grant_q);
        we_sel       = gnt_sel ? we1 : we0;

        case (state_q)
            ST_IDLE: begin
                if (req0 || req1) begin
                    state_d      = ST_ACCESS;
                    grant_d      = gnt_sel;
                    last_grant_d = gnt_sel;
                    mem_en_d     = 1'b1;
                    mem_read_d   = ~we_sel;
                    mem_write_d  = we_sel;
                    mem_addr_d   = gnt_sel ? addr1 : addr0;
                    mem_wdata_d  = gnt_sel ? wdata1 : wdata0;
                end
            end
            ST_ACCESS: begin
                state_d = ST_RESP;
                // mem_read_q is still the latched ~we here, so it marks a read transaction.
                if (mem_read_q) begin
                    rdata_d = mem_rdata;
                end
                ack0_d = ~grant_q;
                ack1_d = grant_q;
            end
            ST_RESP: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        busy_d = (state_d != ST_IDLE);
    end

    assign ack0      = ack0_q;
    assign ack1      = ack1_q;
    assign rdata     = rdata_q;
    assign busy      = busy_q;
    assign mem_en    = mem_en_q;
    assign mem_read  = mem_read_q;
    assign mem_write = mem_write_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;

endmodule

// File: tb/tb_memory_arbiter.sv
// Directed bench for memory_arbiter with a simple asynchronous-read RAM model
// attached to the memory port.
module tb_memory_arbiter;

    logic       clk = 1'b0;
    logic       reset;
    logic       req0, req1, we0, we1;
    logic [6:0] addr0, addr1;
    logic [7:0] wdata0, wdata1;
    logic       ack0, ack1, busy;
    logic [7:0] rdata;
    logic       mem_en, mem_read, mem_write;
    logic [6:0] mem_addr;
    logic [7:0] mem_wdata, mem_rdata;

    logic [7:0] ram [128];
    int         checks   = 0;
    int         failures = 0;
    bit         mon_en   = 1'b0;

    memory_arbiter dut (
        .clk       (clk),
        .reset     (reset),
        .req0      (req0),
        .req1      (req1),
        .we0       (we0),
        .we1       (we1),
        .addr0     (addr0),
        .addr1     (addr1),
        .wdata0    (wdata0),
        .wdata1    (wdata1),
        .ack0      (ack0),
        .ack1      (ack1),
        .rdata     (rdata),
        .busy      (busy),
        .mem_en    (mem_en),
        .mem_read  (mem_read),
        .mem_write (mem_write),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata)
    );

    always #5 clk = ~clk;

    assign mem_rdata = ram[mem_addr];
    always @(posedge clk) begin
        if (mem_en && mem_write) begin
            ram[mem_addr] <= mem_wdata;
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (mon_en && !reset) begin
            check("mutex_rw", 32'(mem_read & mem_write), 32'd0);
            check("one_ack", 32'(ack0 & ack1), 32'd0);
            check("en_in_access", 32'(mem_en & ~busy), 32'd0);
        end
    end

    task automatic check_reset_values(input string tag);
        check({tag, "_ack0"}, 32'(ack0), 32'd0);
        check({tag, "_ack1"}, 32'(ack1), 32'd0);
        check({tag, "_busy"}, 32'(busy), 32'd0);
        check({tag, "_en"}, 32'(mem_en), 32'd0);
        check({tag, "_rd"}, 32'(mem_read), 32'd0);
        check({tag, "_wr"}, 32'(mem_write), 32'd0);
        check({tag, "_addr"}, 32'(mem_addr), 32'd0);
        check({tag, "_wdata"}, 32'(mem_wdata), 32'd0);
        check({tag, "_rdata"}, 32'(rdata), 32'd0);
    endtask

    // Single-requester transaction, entered and left at a falling edge.
    task automatic txn(input int who, input logic we, input logic [6:0] a,
                       input logic [7:0] d, input logic [7:0] exp_rd);
        if (who == 0) begin
            req0 = 1'b1; we0 = we; addr0 = a; wdata0 = d;
        end else begin
            req1 = 1'b1; we1 = we; addr1 = a; wdata1 = d;
        end
        @(negedge clk);
        check("acc_en", 32'(mem_en), 32'd1);
        check("acc_rd", 32'(mem_read), 32'(!we));
        check("acc_wr", 32'(mem_write), 32'(we));
        check("acc_addr", 32'(mem_addr), 32'(a));
        if (we) check("acc_wdata", 32'(mem_wdata), 32'(d));
        check("acc_ack", 32'(ack0 | ack1), 32'd0);
        req0 = 1'b0;
        req1 = 1'b0;
        @(negedge clk);
        check("resp_ack0", 32'(ack0), 32'(who == 0));
        check("resp_ack1", 32'(ack1), 32'(who == 1));
        check("resp_en", 32'(mem_en), 32'd0);
        check("resp_busy", 32'(busy), 32'd1);
        check("resp_rdata", 32'(rdata), 32'(exp_rd));
        @(negedge clk);
        check("idle_busy", 32'(busy), 32'd0);
        check("idle_ack", 32'(ack0 | ack1), 32'd0);
    endtask

    initial begin
        reset = 1'b1;
        req0 = 1'b0; req1 = 1'b0; we0 = 1'b0; we1 = 1'b0;
        addr0 = '0; addr1 = '0; wdata0 = '0; wdata1 = '0;
        @(negedge clk);
        @(negedge clk);
        check_reset_values("rst");
        reset = 1'b0;
        mon_en = 1'b1;

        txn(0, 1'b1, 7'd5, 8'd42, 8'd0);
        txn(0, 1'b0, 7'd5, 8'd0, 8'd42);
        txn(1, 1'b1, 7'd9, 8'd77, 8'd42);
        txn(1, 1'b0, 7'd9, 8'd0, 8'd77);
        txn(0, 1'b1, 7'd127, 8'hFF, 8'd77);
        txn(0, 1'b0, 7'd127, 8'd0, 8'hFF);

        // Abort a write in ACCESS: outputs must clear without waiting for a clock edge.
        req0 = 1'b1; we0 = 1'b1; addr0 = 7'd20; wdata0 = 8'h11;
        @(negedge clk);
        check("abort_en", 32'(mem_en), 32'd1);
        #1 reset = 1'b1;
        #1 check_reset_values("async_rst");
        req0 = 1'b0;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        check("abort_no_ack", 32'(ack0 | ack1), 32'd0);
        check("abort_busy", 32'(busy), 32'd0);

        // Sustained tie straight out of reset: grants go 0,1,0,1.
        req0 = 1'b1; we0 = 1'b0; addr0 = 7'd5;
        req1 = 1'b1; we1 = 1'b0; addr1 = 7'd9;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            check("tie_addr", 32'(mem_addr), (k % 2 == 1) ? 32'd9 : 32'd5);
            check("tie_rd", 32'(mem_read), 32'd1);
            @(negedge clk);
            check("tie_ack0", 32'(ack0), 32'(k % 2 == 0));
            check("tie_ack1", 32'(ack1), 32'(k % 2 == 1));
            check("tie_rdata", 32'(rdata), (k % 2 == 1) ? 32'd77 : 32'd42);
            @(negedge clk);
            check("tie_idle", 32'(busy), 32'd0);
        end
        req0 = 1'b0;
        req1 = 1'b0;
        @(negedge clk);
        check("final_idle", 32'(busy), 32'd0);

        mon_en = 1'b0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
